alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle command front end that is the driving side of the 32-bit ALU's operand/op_code interface.
- Accepts one ALU command per valid/ready handshake and drives the ALU's X, Y and op_code inputs from registers.
- Waits a fixed settle time to cover the ripple add/sub path, then captures Z and the flags.
- Returns the captured result on a valid/ready response channel, so a sequential datapath can use the combinational ALU safely.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU instance.
- SETTLE_CYCLES, 2, number of clock cycles the ALU inputs are held before capture; legal range is 1 or more.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  4  ALU op code
- cmd_x  input  WIDTH  operand X
- cmd_y  input  WIDTH  operand Y
- alu_x  output  WIDTH  registered operand to ALU X
- alu_y  output  WIDTH  registered operand to ALU Y
- alu_op  output  4  registered op code to ALU op_code
- alu_z  input  WIDTH  ALU result
- alu_equal  input  1  ALU equal flag
- alu_overflow  input  1  ALU carry/overflow flag
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_z  output  WIDTH  captured result
- rsp_equal  output  1  captured equal
- rsp_overflow  output  1  captured overflow, masked per op
- rsp_zero  output  1  set when captured result is all zeros
- rsp_illegal  output  1  op code was not a supported op

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- While in reset:
  - state = IDLE.
  - alu_x, alu_y, alu_op, rsp_z and the settle counter are all 0.
  - All rsp flags are 0; rsp_valid = 0; cmd_ready = 0.
  - After reset deasserts, cmd_ready is 1 from the first clock edge onward.
- Legal op codes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR.
  - 0101 ADD, 0110 SUB, 0111 SLT.
  - 1000 SRL, 1001 SLL, 1010 SRA.
  - Every other code (0100, 1011-1111) is illegal.
- State machine states: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, call this the accept cycle A. At the edge ending cycle A, the block registers cmd_x, cmd_y and cmd_op into alu_x, alu_y and alu_op.
  - If the op is legal: load counter = SETTLE_CYCLES-1 and go to SETTLE.
  - If the op is illegal: alu_op is still registered, but the ALU output is ignored. Set rsp_z = 0, rsp_equal = 0, rsp_overflow = 0, rsp_zero = 0, rsp_illegal = 1, and go to RESP. rsp_valid is first high in cycle A+1.
- SETTLE:
  - cmd_ready = 0; alu_* are held constant.
  - When counter == 0, capture at that edge and go to RESP:
    - rsp_z = alu_z
    - rsp_equal = alu_equal
    - rsp_overflow = alu_overflow, but only when alu_op is ADD or SUB; otherwise 0
    - rsp_zero = (alu_z == 0)
    - rsp_illegal = 0
  - Otherwise decrement the counter.
  - rsp_valid is first high in cycle A+SETTLE_CYCLES+1.
- RESP:
  - rsp_valid = 1, cmd_ready = 0.
  - rsp_* are held stable until rsp_ready is seen high.
  - On rsp_valid && rsp_ready, go to IDLE. rsp_valid drops in the next cycle and cmd_ready rises.
  - There is no same-cycle accept-on-retire, so maximum throughput is one command per SETTLE_CYCLES+2 cycles.
- Between commands: alu_x, alu_y and alu_op hold the last accepted values in every state; they change only at an accept edge. rsp_* hold their last values after retirement.
- Reset mid-operation: any in-flight command is discarded with no response. All outputs take their reset values immediately, since reset is asynchronous.
- rsp_ready is ignored outside RESP. cmd_* are ignored when cmd_ready = 0.
- Width rules: no arithmetic is performed in the sequencer except the settle counter, which is $clog2(SETTLE_CYCLES+1) bits wide.

Decomposition:
- Op-code constants come from the existing shared ALU defines file. Add these to it:
  - state encodings: IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2
  - ADD/SUB op-code macros used for overflow masking
- One combinational sub-module, alu_op_legal (4-bit op in, 1-bit legal out), shared with any future decoder.

Test Plan:
- Reset check: with rst high, cmd_valid = 1 -> no accept, rsp_valid = 0, alu_op = 0000. After release -> cmd_ready = 1 on the next cycle.
- ADD, SETTLE_CYCLES = 2: cmd_x = 0xFFFFFFFF, cmd_y = 1, op 0101 -> rsp_valid first high at A+3, rsp_z = 0, rsp_zero = 1, rsp_overflow = 1, rsp_illegal = 0.
- Back-pressure: AND 0xF0F0F0F0 & 0x0FF00FF0 with rsp_ready held low 5 cycles -> rsp_z = 0x00F000F0 stable across all 5 cycles, cmd_ready = 0 throughout, new cmd_valid not accepted.
- Overflow masking: XOR with ALU model driving alu_overflow = 1 -> rsp_overflow = 0. EQ case, X = Y = 0x12345678 with op 0110 -> rsp_equal = 1, rsp_z = 0.
- Illegal op 1100 -> rsp_valid at A+1, rsp_illegal = 1, rsp_z = 0. Next legal command (OR 0x1 | 0x2) -> rsp_z = 0x3, rsp_illegal = 0.
- Mid-flight reset: assert rst during SETTLE of a SUB -> no rsp_valid ever appears for it, all outputs = 0. A subsequent command completes normally.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared ALU op codes and sequencer state encoding
package alu_sequencer_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_op_legal.sv
// rtl/alu_op_legal.sv - flags which 4-bit op codes the ALU implements
module alu_op_legal
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] op_i,
    output logic       legal_o
);

    always_comb begin
        legal_o = 1'b0;
        case (op_i)
            OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_ADD, OP_SUB, OP_SLT,
            OP_SRL, OP_SLL, OP_SRA: legal_o = 1'b1;
            default:                legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - holds ALU operands for a settle window, then returns Z and flags
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_equal,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_equal,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_illegal
);

    localparam int            CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             live_q;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [3:0]       op_q, op_d;
    logic             eq_q, eq_d, ovf_q, ovf_d, zero_q, zero_d, ill_q, ill_d;
    logic             op_legal;
    logic             accept;

    alu_op_legal u_legal (
        .op_i    (cmd_op),
        .legal_o (op_legal)
    );

    // live_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready    = live_q && (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign accept       = cmd_valid && cmd_ready;
    assign alu_x        = x_q;
    assign alu_y        = y_q;
    assign alu_op       = op_q;
    assign rsp_z        = z_q;
    assign rsp_equal    = eq_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign rsp_illegal  = ill_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        z_d     = z_q;
        eq_d    = eq_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d  = cmd_x;
                    y_d  = cmd_y;
                    op_d = cmd_op;
                    if (op_legal) begin
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        z_d     = '0;
                        eq_d    = 1'b0;
                        ovf_d   = 1'b0;
                        zero_d  = 1'b0;
                        ill_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    z_d     = alu_z;
                    eq_d    = alu_equal;
                    // only the add/sub ripple path produces a meaningful carry
                    ovf_d   = alu_overflow && ((op_q == OP_ADD) || (op_q == OP_SUB));
                    zero_d  = (alu_z == '0);
                    ill_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            z_q     <= '0;
            eq_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            z_q     <= z_d;
            eq_q    <= eq_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    localparam int W      = 32;
    localparam int SETTLE = 2;

    typedef struct {
        logic [W-1:0] z;
        logic         eq;
        logic         ovf;
        logic         zero;
        logic         ill;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic         cmd_ready, rsp_valid;
    logic [3:0]   cmd_op = 4'b0, alu_op;
    logic [W-1:0] cmd_x = '0, cmd_y = '0, alu_x, alu_y, alu_z, rsp_z;
    logic         alu_equal, alu_overflow, force_ovf = 1'b0;
    logic         rsp_equal, rsp_overflow, rsp_zero, rsp_illegal;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .alu_equal(alu_equal), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
        .rsp_equal(rsp_equal), .rsp_overflow(rsp_overflow),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
    );

    function automatic logic [W:0] alu_ref(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        case (op)
            4'b0000: r = {1'b0, x & y};
            4'b0001: r = {1'b0, x | y};
            4'b0010: r = {1'b0, x ^ y};
            4'b0011: r = {1'b0, ~(x | y)};
            4'b0101: r = {1'b0, x} + {1'b0, y};
            4'b0110: r = {1'b0, x} + {1'b0, ~y} + 33'd1;
            4'b0111: r = {32'd0, ($signed(x) < $signed(y))};
            4'b1000: r = {1'b0, x >> y[4:0]};
            4'b1001: r = {1'b0, x << y[4:0]};
            4'b1010: r = {1'b0, $signed(x) >>> y[4:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [W:0] r;
        r            = alu_ref(alu_op, alu_x, alu_y);
        alu_z        = r[W-1:0];
        alu_equal    = (alu_x == alu_y);
        alu_overflow = r[W] | force_ovf;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W:0] r;
        logic legal;
        legal = (op != 4'b0100) && (op <= 4'b1010);
        r = alu_ref(op, x, y);
        @(negedge clk);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
        chk("accept_ready", {31'd0, cmd_ready}, 1);
        if (legal) begin
            e.z    = r[W-1:0];
            e.eq   = (x == y);
            e.ovf  = (op == 4'b0101 || op == 4'b0110) ? (r[W] | force_ovf) : 1'b0;
            e.zero = (r[W-1:0] == '0);
            e.ill  = 1'b0;
            e.lat  = SETTLE + 1;
        end else begin
            e.z = '0; e.eq = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; e.ill = 1'b1;
            e.lat = 1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat;
        logic [W-1:0] held_x;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = i; break; end
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, W'(lat), W'(e.lat));
        chk({tag, "_z"}, rsp_z, e.z);
        chk({tag, "_flags"}, {28'd0, rsp_equal, rsp_overflow, rsp_zero, rsp_illegal},
            {28'd0, e.eq, e.ovf, e.zero, e.ill});
        if (hold > 0) begin
            held_x = alu_x;
            cmd_valid = 1'b1; cmd_op = 4'b0001; cmd_x = 32'hDEAD_BEEF; cmd_y = 32'h5;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "_bp_state"}, {29'd0, rsp_valid, cmd_ready, (rsp_z === e.z)}, 32'b101);
            end
            chk({tag, "_bp_no_accept"}, alu_x, held_x);
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_retire"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
        chk({tag, "_z_held"}, rsp_z, e.z);
    endtask

    initial begin
        int seen;
        // Reset: a pending command must not be taken while rst is high
        cmd_valid = 1'b1; cmd_op = 4'b0101; cmd_x = 32'h1234; cmd_y = 32'h1; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, rsp_valid, cmd_ready, alu_op}, 32'd0);
        chk("reset_alu_x", alu_x, 32'd0);
        chk("reset_rsp_z", rsp_z, 32'd0);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b0;
        #1 chk("ready_before_edge", {31'd0, cmd_ready}, 0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, cmd_ready}, 1);

        issue(4'b0101, 32'hFFFF_FFFF, 32'h1);
        collect("add_wrap", 0);
        chk("add_wrap_spec", {27'd0, rsp_zero, rsp_overflow, rsp_illegal, 2'b00}, 32'b11000);

        issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        collect("and_bp", 5);
        chk("and_bp_value", rsp_z, 32'h00F0_00F0);

        force_ovf = 1'b1;
        issue(4'b0010, 32'hAAAA_0000, 32'h5555_FFFF);
        collect("xor_mask", 0);
        chk("xor_mask_ovf", {31'd0, rsp_overflow}, 0);
        force_ovf = 1'b0;

        issue(4'b0110, 32'h1234_5678, 32'h1234_5678);
        collect("sub_eq", 0);
        chk("sub_eq_spec", {30'd0, rsp_equal, (rsp_z == '0)}, 32'b11);

        issue(4'b1100, 32'h7, 32'h9);
        collect("illegal", 0);
        issue(4'b0001, 32'h1, 32'h2);
        collect("or_after_illegal", 0);
        chk("or_value", rsp_z, 32'h3);

        issue(4'b0111, 32'h8000_0000, 32'h1);
        collect("slt", 0);
        issue(4'b1010, 32'h8000_0010, 32'h4);
        collect("sra", 0);
        issue(4'b1001, 32'h0000_0001, 32'd31);
        collect("sll", 0);

        // Reset during SETTLE discards the in-flight SUB
        issue(4'b0110, 32'h10, 32'h3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {21'd0, rsp_valid, cmd_ready, rsp_equal, rsp_overflow,
                               rsp_zero, rsp_illegal, alu_op}, 32'd0);
        chk("midrst_alu_x", alu_x | alu_y | rsp_z, 32'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", W'(seen), 32'd0);
        issue(4'b0110, 32'h10, 32'h3);
        collect("sub_after_rst", 0);
        chk("scoreboard_empty", W'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
